// File: rtl/wbu_rf_writer_if.sv
// Bundle between the write-back unit, the execute stage, the memory read port
// and the register-file write port.
interface wbu_rf_writer_if #(
   parameter int CPU_WIDTH  = 32,
   parameter int REG_ADDR_W = 5
);
   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high; the producer holds its payload steady while valid is high, and valid
   // never depends on ready. Here in_ready and mem_rready are pure state decodes.
   logic                  in_valid;
   logic                  in_ready;
   logic [REG_ADDR_W-1:0] in_rd;
   logic                  in_rf_wen;
   logic                  in_is_load;
   logic [2:0]            in_funct3;
   logic [CPU_WIDTH-1:0]  in_result;
   logic [CPU_WIDTH-1:0]  in_pc;
   logic                  mem_rvalid;
   logic                  mem_rready;
   logic [CPU_WIDTH-1:0]  mem_rdata;
   logic                  rf_wen;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [CPU_WIDTH-1:0]  rf_wdata;
   logic                  commit_valid;
   logic [CPU_WIDTH-1:0]  commit_pc;

   modport slave (
      input  in_valid, in_rd, in_rf_wen, in_is_load, in_funct3, in_result, in_pc,
      input  mem_rvalid, mem_rdata,
      output in_ready, mem_rready,
      output rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc
   );

   modport master (
      output in_valid, in_rd, in_rf_wen, in_is_load, in_funct3, in_result, in_pc,
      output mem_rvalid, mem_rdata,
      input  in_ready, mem_rready,
      input  rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc
   );
endinterface

// File: rtl/wbu_rf_writer.sv
// Write-back unit: retires execute-stage results into the register file,
// waiting on memory for loads and extending the returned byte/half/word.
module wbu_rf_writer #(
   parameter int CPU_WIDTH  = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 255
) (
   input  logic            clk,
   input  logic            rst,
   wbu_rf_writer_if.slave  bus,
   output logic            busy,
   output logic            timeout_err
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Abort is decided on the TIMEOUT-th consecutive empty WAIT_MEM cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t                state_q, state_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic                  wen_q, wen_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            addr_q, addr_d;
   logic [CPU_WIDTH-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rf_wen_q, rf_wen_d;
   logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [CPU_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
   logic                  commit_valid_q, commit_valid_d;
   logic [CPU_WIDTH-1:0]  commit_pc_q, commit_pc_d;
   logic                  timeout_err_q, timeout_err_d;

   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [CPU_WIDTH-1:0]  load_ext;

   always_comb begin
      byte_sel = bus.mem_rdata[{addr_q, 3'b000} +: 8];
      half_sel = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_ext = {{(CPU_WIDTH-8){byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {{(CPU_WIDTH-8){1'b0}}, byte_sel};
         3'b001:  load_ext = {{(CPU_WIDTH-16){half_sel[15]}}, half_sel};
         3'b101:  load_ext = {{(CPU_WIDTH-16){1'b0}}, half_sel};
         default: load_ext = bus.mem_rdata;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      rd_d           = rd_q;
      wen_d          = wen_q;
      funct3_d       = funct3_q;
      addr_d         = addr_q;
      pc_d           = pc_q;
      cnt_d          = cnt_q;
      rf_wen_d       = 1'b0;
      rf_waddr_d     = rf_waddr_q;
      rf_wdata_d     = rf_wdata_q;
      commit_valid_d = 1'b0;
      commit_pc_d    = commit_pc_q;
      timeout_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (bus.in_is_load) begin
                  state_d  = WAIT_MEM;
                  rd_d     = bus.in_rd;
                  wen_d    = bus.in_rf_wen;
                  funct3_d = bus.in_funct3;
                  addr_d   = bus.in_result[1:0];
                  pc_d     = bus.in_pc;
                  cnt_d    = '0;
               end else begin
                  rf_wen_d       = bus.in_rf_wen && (bus.in_rd != '0);
                  rf_waddr_d     = bus.in_rd;
                  rf_wdata_d     = bus.in_result;
                  commit_valid_d = 1'b1;
                  commit_pc_d    = bus.in_pc;
               end
            end
         end
         WAIT_MEM: begin
            // Data arriving on the last allowed cycle still wins over the abort.
            if (bus.mem_rvalid) begin
               state_d        = IDLE;
               rf_wen_d       = wen_q && (rd_q != '0);
               rf_waddr_d     = rd_q;
               rf_wdata_d     = load_ext;
               commit_valid_d = 1'b1;
               commit_pc_d    = pc_q;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               state_d       = IDLE;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         rd_q           <= '0;
         wen_q          <= 1'b0;
         funct3_q       <= '0;
         addr_q         <= '0;
         pc_q           <= '0;
         cnt_q          <= '0;
         rf_wen_q       <= 1'b0;
         rf_waddr_q     <= '0;
         rf_wdata_q     <= '0;
         commit_valid_q <= 1'b0;
         commit_pc_q    <= '0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_q           <= rd_d;
         wen_q          <= wen_d;
         funct3_q       <= funct3_d;
         addr_q         <= addr_d;
         pc_q           <= pc_d;
         cnt_q          <= cnt_d;
         rf_wen_q       <= rf_wen_d;
         rf_waddr_q     <= rf_waddr_d;
         rf_wdata_q     <= rf_wdata_d;
         commit_valid_q <= commit_valid_d;
         commit_pc_q    <= commit_pc_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.mem_rready   = (state_q == WAIT_MEM);
   assign bus.rf_wen       = rf_wen_q;
   assign bus.rf_waddr     = rf_waddr_q;
   assign bus.rf_wdata     = rf_wdata_q;
   assign bus.commit_valid = commit_valid_q;
   assign bus.commit_pc    = commit_pc_q;
   assign busy             = (state_q != IDLE);
   assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_wbu_rf_writer.sv
// Bench for wbu_rf_writer: unit a uses the default timeout, unit b uses TIMEOUT=4.
// A transaction-level model predicts every output each cycle; directed tests add literals.
module tb_wbu_rf_writer;

   logic clk;
   logic rst;

   logic        sel;
   logic        d_valid, d_wen, d_load, d_rvalid;
   logic [4:0]  d_rd;
   logic [2:0]  d_f3;
   logic [31:0] d_result, d_pc, d_rdata;

   logic busy_a, busy_b, terr_a, terr_b;

   int n_vec = 0;
   int n_err = 0;
   int wen_a = 0, cv_a = 0, wen_b = 0, cv_b = 0, te_b = 0;

   wbu_rf_writer_if #(.CPU_WIDTH(32), .REG_ADDR_W(5)) bus_a ();
   wbu_rf_writer_if #(.CPU_WIDTH(32), .REG_ADDR_W(5)) bus_b ();

   assign bus_a.in_valid   = d_valid & ~sel;
   assign bus_b.in_valid   = d_valid & sel;
   assign bus_a.mem_rvalid = d_rvalid & ~sel;
   assign bus_b.mem_rvalid = d_rvalid & sel;
   assign bus_a.in_rd      = d_rd;      assign bus_b.in_rd      = d_rd;
   assign bus_a.in_rf_wen  = d_wen;     assign bus_b.in_rf_wen  = d_wen;
   assign bus_a.in_is_load = d_load;    assign bus_b.in_is_load = d_load;
   assign bus_a.in_funct3  = d_f3;      assign bus_b.in_funct3  = d_f3;
   assign bus_a.in_result  = d_result;  assign bus_b.in_result  = d_result;
   assign bus_a.in_pc      = d_pc;      assign bus_b.in_pc      = d_pc;
   assign bus_a.mem_rdata  = d_rdata;   assign bus_b.mem_rdata  = d_rdata;

   wbu_rf_writer #(.CPU_WIDTH(32), .REG_ADDR_W(5), .TIMEOUT(255)) u_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave), .busy(busy_a), .timeout_err(terr_a));
   wbu_rf_writer #(.CPU_WIDTH(32), .REG_ADDR_W(5), .TIMEOUT(4)) u_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave), .busy(busy_b), .timeout_err(terr_b));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   typedef struct {
      logic        busy;
      logic [4:0]  rd;
      logic        wen;
      logic [2:0]  f3;
      logic [1:0]  a;
      logic [31:0] pc;
      int          waitc;
      logic        rf_wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        cv;
      logic [31:0] cpc;
      logic        terr;
   } mdl_t;

   mdl_t m[2];
   int   to_lim[2] = '{255, 4};

   function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
      logic [31:0] s;
      if (f3[1]) return w;
      if (f3[0]) begin
         s = (w >> (16 * a[1])) & 32'h0000FFFF;
         if (!f3[2] && s[15]) s = s | 32'hFFFF0000;
      end else begin
         s = (w >> (8 * a)) & 32'h000000FF;
         if (!f3[2] && s[7]) s = s | 32'hFFFFFF00;
      end
      return s;
   endfunction

   always @(posedge clk or posedge rst) begin
      mdl_t nx;
      logic vk, rk;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m[k] <= '{default: 0};
         end else begin
            nx = m[k];
            vk = d_valid && (sel == k[0]);
            rk = d_rvalid && (sel == k[0]);
            nx.rf_wen = 1'b0;
            nx.cv     = 1'b0;
            nx.terr   = 1'b0;
            if (!m[k].busy) begin
               if (vk && d_load) begin
                  nx.busy = 1'b1; nx.rd = d_rd; nx.wen = d_wen; nx.f3 = d_f3;
                  nx.a = d_result[1:0]; nx.pc = d_pc; nx.waitc = 0;
               end else if (vk) begin
                  nx.rf_wen = d_wen && (d_rd != 0); nx.waddr = d_rd; nx.wdata = d_result;
                  nx.cv = 1'b1; nx.cpc = d_pc;
               end
            end else if (rk) begin
               nx.busy = 1'b0; nx.rf_wen = m[k].wen && (m[k].rd != 0); nx.waddr = m[k].rd;
               nx.wdata = model_ext(m[k].f3, m[k].a, d_rdata); nx.cv = 1'b1; nx.cpc = m[k].pc;
            end else begin
               nx.waitc = m[k].waitc + 1;
               if (to_lim[k] != 0 && nx.waitc == to_lim[k]) begin
                  nx.busy = 1'b0; nx.terr = 1'b1;
               end
            end
            m[k] <= nx;
         end
      end
   end

   // ---------------- scoreboard / compare ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_unit(input int k, input logic ir, input logic mr, input logic wen,
                           input logic [4:0] wa, input logic [31:0] wd, input logic cv,
                           input logic [31:0] cpc, input logic bsy, input logic te);
      chk($sformatf("u%0d.in_ready", k),     {31'd0, ir},  {31'd0, !m[k].busy});
      chk($sformatf("u%0d.mem_rready", k),   {31'd0, mr},  {31'd0, m[k].busy});
      chk($sformatf("u%0d.busy", k),         {31'd0, bsy}, {31'd0, m[k].busy});
      chk($sformatf("u%0d.rf_wen", k),       {31'd0, wen}, {31'd0, m[k].rf_wen});
      chk($sformatf("u%0d.rf_waddr", k),     {27'd0, wa},  {27'd0, m[k].waddr});
      chk($sformatf("u%0d.rf_wdata", k),     wd,           m[k].wdata);
      chk($sformatf("u%0d.commit_valid", k), {31'd0, cv},  {31'd0, m[k].cv});
      chk($sformatf("u%0d.commit_pc", k),    cpc,          m[k].cpc);
      chk($sformatf("u%0d.timeout_err", k),  {31'd0, te},  {31'd0, m[k].terr});
   endtask

   always @(negedge clk) begin
      chk_unit(0, bus_a.in_ready, bus_a.mem_rready, bus_a.rf_wen, bus_a.rf_waddr,
               bus_a.rf_wdata, bus_a.commit_valid, bus_a.commit_pc, busy_a, terr_a);
      chk_unit(1, bus_b.in_ready, bus_b.mem_rready, bus_b.rf_wen, bus_b.rf_waddr,
               bus_b.rf_wdata, bus_b.commit_valid, bus_b.commit_pc, busy_b, terr_b);
      if (bus_a.rf_wen) wen_a++;
      if (bus_a.commit_valid) cv_a++;
      if (bus_b.rf_wen) wen_b++;
      if (bus_b.commit_valid) cv_b++;
      if (terr_b) te_b++;
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
      d_valid = 1'b1; d_load = 1'b0; d_wen = 1'b1; d_rd = rd; d_f3 = 3'b000;
      d_result = res; d_pc = pc;
   endtask

   // Starts and ends 1 time unit after a rising edge; checks the write literally.
   task automatic do_load(input string nm, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] word, input int delay,
                          input logic [31:0] exp);
      d_valid = 1'b1; d_load = 1'b1; d_wen = 1'b1; d_rd = rd; d_f3 = f3;
      d_result = addr; d_pc = 32'h8000_0000 | addr;
      cyc();
      d_valid = 1'b0;
      repeat (delay) begin
         @(negedge clk);
         chk({nm, ".stall_in_ready"}, {31'd0, sel ? bus_b.in_ready : bus_a.in_ready}, 32'd0);
         chk({nm, ".stall_busy"}, {31'd0, sel ? busy_b : busy_a}, 32'd1);
         cyc();
      end
      d_rvalid = 1'b1; d_rdata = word;
      cyc();
      d_rvalid = 1'b0;
      @(negedge clk);
      chk({nm, ".wen"}, {31'd0, sel ? bus_b.rf_wen : bus_a.rf_wen}, {31'd0, rd != 0});
      chk({nm, ".wdata"}, sel ? bus_b.rf_wdata : bus_a.rf_wdata, exp);
      chk({nm, ".in_ready"}, {31'd0, sel ? bus_b.in_ready : bus_a.in_ready}, 32'd1);
      cyc();
   endtask

   // ---------------- stimulus ----------------
   int s_wen, s_cv, s_te;

   initial begin
      sel = 1'b0; d_valid = 1'b0; d_wen = 1'b0; d_load = 1'b0; d_rvalid = 1'b0;
      d_rd = '0; d_f3 = '0; d_result = '0; d_pc = '0; d_rdata = '0;
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      @(negedge clk);
      chk("reset.in_ready", {31'd0, bus_a.in_ready}, 32'd1);
      chk("reset.rf_wdata", bus_a.rf_wdata, 32'd0);
      chk("reset.commit_pc", bus_a.commit_pc, 32'd0);
      cyc();

      // back-to-back ALU writes
      drive_alu(5'd5, 32'h0000_1234, 32'h0000_0100);
      cyc();
      drive_alu(5'd6, 32'h0000_DEAD, 32'h0000_0104);
      @(negedge clk);
      chk("b2b0.waddr", {27'd0, bus_a.rf_waddr}, 32'd5);
      chk("b2b0.wdata", bus_a.rf_wdata, 32'h0000_1234);
      chk("b2b0.pc", bus_a.commit_pc, 32'h0000_0100);
      chk("b2b0.in_ready", {31'd0, bus_a.in_ready}, 32'd1);
      cyc();
      d_valid = 1'b0;
      @(negedge clk);
      chk("b2b1.waddr", {27'd0, bus_a.rf_waddr}, 32'd6);
      chk("b2b1.wdata", bus_a.rf_wdata, 32'h0000_DEAD);
      chk("b2b1.pc", bus_a.commit_pc, 32'h0000_0104);
      chk("b2b1.wen", {31'd0, bus_a.rf_wen}, 32'd1);
      cyc();

      // load extension table
      do_load("lb3",   5'd7, 3'b000, 32'h0000_1003, 32'h80FF_7F01, 0, 32'hFFFF_FF80);
      do_load("lbu3",  5'd7, 3'b100, 32'h0000_1003, 32'h80FF_7F01, 1, 32'h0000_0080);
      do_load("lh0",   5'd7, 3'b001, 32'h0000_1000, 32'h80FF_7F01, 0, 32'h0000_7F01);
      do_load("lh1",   5'd7, 3'b001, 32'h0000_1001, 32'h80FF_7F01, 0, 32'h0000_7F01);
      do_load("lh2",   5'd7, 3'b001, 32'h0000_1002, 32'h80FF_7F01, 2, 32'hFFFF_80FF);
      do_load("lhu2",  5'd7, 3'b101, 32'h0000_1002, 32'h80FF_7F01, 0, 32'h0000_80FF);
      do_load("lw",    5'd7, 3'b010, 32'h0000_1003, 32'h80FF_7F01, 0, 32'h80FF_7F01);
      do_load("f3_011", 5'd7, 3'b011, 32'h0000_1001, 32'h80FF_7F01, 0, 32'h80FF_7F01);
      do_load("lb1",   5'd7, 3'b000, 32'h0000_1001, 32'h80FF_7F01, 0, 32'h0000_007F);

      // stray mem_rvalid while idle, then a long stall
      d_rvalid = 1'b1; d_rdata = 32'hDEAD_BEEF;
      cyc();
      d_rvalid = 1'b0;
      s_wen = wen_a;
      do_load("stall", 5'd9, 3'b010, 32'h0000_2000, 32'h1122_3344, 7, 32'h1122_3344);
      cyc();
      chk("stall.one_wen", wen_a - s_wen, 32'd1);

      // writes to x0
      s_wen = wen_a; s_cv = cv_a;
      drive_alu(5'd0, 32'h0000_0055, 32'h0000_0200);
      cyc();
      d_valid = 1'b0;
      cyc();
      do_load("lw_x0", 5'd0, 3'b010, 32'h0000_3000, 32'hAAAA_5555, 2, 32'hAAAA_5555);
      chk("x0.no_wen", wen_a - s_wen, 32'd0);
      chk("x0.two_commits", cv_a - s_cv, 32'd2);

      // timeout on unit b
      sel = 1'b1;
      cyc();
      s_wen = wen_b; s_cv = cv_b; s_te = te_b;
      d_valid = 1'b1; d_load = 1'b1; d_wen = 1'b1; d_rd = 5'd3; d_f3 = 3'b010;
      d_result = 32'h0000_4000; d_pc = 32'h0000_0400;
      cyc();
      d_valid = 1'b0;
      repeat (4) cyc();
      @(negedge clk);
      chk("to.err", {31'd0, terr_b}, 32'd1);
      chk("to.busy", {31'd0, busy_b}, 32'd0);
      cyc();
      cyc();
      chk("to.one_err", te_b - s_te, 32'd1);
      chk("to.no_wen", wen_b - s_wen, 32'd0);
      chk("to.no_commit", cv_b - s_cv, 32'd0);

      // data on the last allowed cycle wins
      s_te = te_b;
      do_load("to_edge", 5'd3, 3'b100, 32'h0000_4001, 32'h80FF_7F01, 3, 32'h0000_007F);
      cyc();
      chk("to_edge.no_err", te_b - s_te, 32'd0);
      sel = 1'b0;
      cyc();

      // asynchronous reset while a load is pending
      s_wen = wen_a; s_cv = cv_a;
      d_valid = 1'b1; d_load = 1'b1; d_wen = 1'b1; d_rd = 5'd4; d_f3 = 3'b010;
      d_result = 32'h0000_5000; d_pc = 32'h0000_0500;
      cyc();
      d_valid = 1'b0;
      cyc();
      #2 rst = 1'b1;
      #1;
      chk("rst.busy", {31'd0, busy_a}, 32'd0);
      chk("rst.rf_wdata", bus_a.rf_wdata, 32'd0);
      chk("rst.rf_waddr", {27'd0, bus_a.rf_waddr}, 32'd0);
      chk("rst.commit_pc", bus_a.commit_pc, 32'd0);
      #3 rst = 1'b0;
      cyc();
      d_rvalid = 1'b1; d_rdata = 32'h0BAD_0BAD;
      cyc();
      d_rvalid = 1'b0;
      drive_alu(5'd8, 32'h0000_CAFE, 32'h0000_0300);
      cyc();
      d_valid = 1'b0;
      @(negedge clk);
      chk("post_rst.wen", {31'd0, bus_a.rf_wen}, 32'd1);
      chk("post_rst.waddr", {27'd0, bus_a.rf_waddr}, 32'd8);
      chk("post_rst.wdata", bus_a.rf_wdata, 32'h0000_CAFE);
      cyc();
      chk("post_rst.one_wen", wen_a - s_wen, 32'd1);
      chk("post_rst.one_commit", cv_a - s_cv, 32'd1);

      repeat (2) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wbu_rf_writer.md
Name: wbu_rf_writer

Overview:
- Write-back unit: the producer side of the register-file write port (en/waddr/wdata).
- Accepts completed instructions from the execute stage over a valid/ready handshake.
- For loads, waits for the memory read response, then byte/half selects and sign/zero extends the data.
- Drives a registered one-cycle register-file write pulse and a commit pulse (pc) for the simulation difftest/trap logic.

Parameters:
- CPU_WIDTH, 32, data/address width.
- REG_ADDR_W, 5, register index width.
- TIMEOUT, 255, maximum WAIT_MEM cycles without mem_rvalid before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  high only in IDLE.
- in_rd  in  REG_ADDR_W  destination register.
- in_rf_wen  in  1  instruction writes rd.
- in_is_load  in  1  result comes from memory.
- in_funct3  in  3  load type.
- in_result  in  CPU_WIDTH  ALU result; for loads, the effective address (bits [1:0] used).
- in_pc  in  CPU_WIDTH  instruction pc.
- mem_rvalid  in  1  load data valid.
- mem_rready  out  1  high only in WAIT_MEM.
- mem_rdata  in  CPU_WIDTH  aligned 32-bit word.
- rf_wen  out  1  register-file write enable, single-cycle pulse.
- rf_waddr  out  REG_ADDR_W  write address.
- rf_wdata  out  CPU_WIDTH  write data.
- commit_valid  out  1  single-cycle pulse, one per retired instruction.
- commit_pc  out  CPU_WIDTH  pc of the retired instruction.
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse on load abort.

Behaviour:
- Reset values:
  - state = IDLE.
  - rf_wen = 0, rf_waddr = 0, rf_wdata = 0.
  - commit_valid = 0, commit_pc = 0.
  - timeout_err = 0, timeout counter = 0.
- Reset mid-load: return to IDLE and discard the pending load; no write or commit is issued.
- Accept: a transfer occurs on in_valid && in_ready at edge t. The unit latches rd, rf_wen, funct3, result[1:0], result and pc.
- Non-load accepted at t:
  - Cycle t+1: rf_wen = in_rf_wen && (in_rd != 0), rf_waddr = rd, rf_wdata = result, commit_valid = 1, commit_pc = pc.
  - State stays IDLE, so non-loads sustain one per cycle back-to-back.
- Load accepted at t:
  - State becomes WAIT_MEM at t+1; in_ready = 0 and mem_rready = 1.
  - On mem_rvalid at edge u: cycle u+1 issues the write and commit pulses with the extended data, and the state returns to IDLE.
  - in_ready is high again in cycle u+1.
  - Minimum load occupancy is 2 cycles.
- mem_rvalid while IDLE is ignored, because mem_rready = 0.
- Load extension (b = addr[1:0]):
  - 000 LB: sign-extend byte b.
  - 100 LBU: zero-extend byte b.
  - 001 LH: sign-extend half addr[1]; addr[0] is ignored.
  - 101 LHU: zero-extend half addr[1].
  - 010 LW, and 011/110/111: full word; addr bits are ignored.
- Writes to x0:
  - rd == 0 never asserts rf_wen.
  - commit_valid still pulses.
  - A load to x0 still waits for the memory response.
- Timeout:
  - The counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without mem_rvalid.
  - When the count reaches TIMEOUT (and TIMEOUT != 0): return to IDLE next cycle and pulse timeout_err. No rf write and no commit.
  - If mem_rvalid arrives in the same cycle the count reaches TIMEOUT, the data wins: normal write, no error.
- rf_waddr, rf_wdata and commit_pc hold their last values when the pulses are low.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> all outputs 0 immediately; in_ready = 1 after release.
- Back-to-back ALU writes: accept rd=5 data 0x1234 then rd=6 data 0xDEAD on consecutive cycles -> rf_wen pulses in both following cycles with (5, 0x1234) then (6, 0xDEAD); commit_pc matches each pc; in_ready stays 1.
- Load extension: mem_rdata = 0x80FF7F01.
  - LB at addr ..03 -> 0xFFFFFF80.
  - LBU ..03 -> 0x00000080.
  - LH ..00 -> 0x00007F01.
  - LH ..02 -> 0xFFFF80FF.
  - LHU ..02 -> 0x000080FF.
  - LW -> 0x80FF7F01.
  - Each write lands the cycle after the mem_rvalid handshake.
- Load stall: mem_rvalid delayed 7 cycles -> in_ready = 0 and busy = 1 throughout; a stray mem_rvalid before the load is accepted is ignored; exactly one rf_wen.
- x0 handling: ALU to rd=0 and LW to rd=0 -> rf_wen never asserts; commit_valid pulses twice.
- Timeout/reset: TIMEOUT = 4 with no mem_rvalid -> timeout_err pulses once, no rf_wen/commit, returns to IDLE. Separately, rst during WAIT_MEM -> no write; the next ALU op is accepted normally.
